// File: rtl/alu_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mdu_seq
//  Description : RV32I-compatible ALU with iterative unsigned multiply and
//                (optionally) unsigned divide. Valid/ready handshake on both
//                sides. Single-cycle ops have 1-cycle latency; MUL/MULHU and
//                DIVU/REMU iterate one bit per cycle (WIDTH+1 cycle latency).
//  Ports       : clk, reset (async, active-high)
//                in_valid/in_ready, A, B, Control_in   - operation request
//                out_valid/out_ready, ALU_Result, zero - registered result
//  Config      : define ALU_DIV_EN to build the DIVU/REMU datapath; without
//                it, codes 1100/1101 behave as unused codes.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Control_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Result,
    output logic             zero
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
`ifdef ALU_DIV_EN
    localparam logic [1:0] c_st_div  = 2'd2;
`endif
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [3:0] c_op_and   = 4'b0000;
    localparam logic [3:0] c_op_or    = 4'b0001;
    localparam logic [3:0] c_op_add   = 4'b0010;
    localparam logic [3:0] c_op_xor   = 4'b0011;
    localparam logic [3:0] c_op_sll   = 4'b0100;
    localparam logic [3:0] c_op_srl   = 4'b0101;
    localparam logic [3:0] c_op_sub   = 4'b0110;
    localparam logic [3:0] c_op_sra   = 4'b0111;
    localparam logic [3:0] c_op_slt   = 4'b1000;
    localparam logic [3:0] c_op_sltu  = 4'b1001;
    localparam logic [3:0] c_op_mul   = 4'b1010;
    localparam logic [3:0] c_op_mulhu = 4'b1011;
`ifdef ALU_DIV_EN
    localparam logic [3:0] c_op_divu  = 4'b1100;
    localparam logic [3:0] c_op_remu  = 4'b1101;
`endif

    localparam logic [SHAMT_W:0] c_iter = (SHAMT_W+1)'(WIDTH);
    localparam logic [SHAMT_W:0] c_last = (SHAMT_W+1)'(1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic [SHAMT_W:0]   r_cnt;

    // Multiplier: r_prod starts as {0, B}; each step conditionally adds the
    // multiplicand into the upper half and shifts right, so after WIDTH
    // steps it holds the full 2*WIDTH-bit product.
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_mul_hi;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_div;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_single_res;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;

    assign in_ready   = (r_state == c_st_idle) || ((r_state == c_st_done) && out_ready);
    assign out_valid  = (r_state == c_st_done);
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (Control_in == c_op_mul) || (Control_in == c_op_mulhu);
    assign w_shamt    = B[SHAMT_W-1:0];
    assign ALU_Result = r_result;
    assign zero       = r_zero;

    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    // Restoring divider: the dividend shifts out of r_quo MSB-first into the
    // partial remainder while quotient bits shift in at the LSB. A zero
    // divisor naturally yields quotient all-ones and remainder A.
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic               r_rem_sel;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

    assign w_is_div   = (Control_in == c_op_divu) || (Control_in == c_op_remu);
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_div};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
`else
    assign w_is_div   = 1'b0;
`endif

    // Single-cycle result; MUL/DIV and unused codes fall to zero here.
    always_comb begin
        w_single_res = '0;
        case (Control_in)
            c_op_and:  w_single_res = A & B;
            c_op_or:   w_single_res = A | B;
            c_op_add:  w_single_res = A + B;
            c_op_sub:  w_single_res = A - B;
            c_op_xor:  w_single_res = A ^ B;
            c_op_sll:  w_single_res = A << w_shamt;
            c_op_srl:  w_single_res = A >> w_shamt;
            c_op_sra:  w_single_res = WIDTH'($signed(A) >>> w_shamt);
            c_op_slt:  w_single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            c_op_sltu: w_single_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default:   w_single_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_mul_hi  <= 1'b0;
`ifdef ALU_DIV_EN
            r_div     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_rem_sel <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_mcand  <= A;
                            r_prod   <= {{WIDTH{1'b0}}, B};
                            r_mul_hi <= (Control_in == c_op_mulhu);
                            r_cnt    <= c_iter;
                            r_state  <= c_st_mul;
                        end
`ifdef ALU_DIV_EN
                        else if (w_is_div) begin
                            r_div     <= B;
                            r_quo     <= A;
                            r_rem     <= '0;
                            r_rem_sel <= (Control_in == c_op_remu);
                            r_cnt     <= c_iter;
                            r_state   <= c_st_div;
                        end
`endif
                        else begin
                            r_result <= w_single_res;
                            r_zero   <= (w_single_res == '0);
                            r_state  <= c_st_done;
                        end
                    end else if (r_state == c_st_done && out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_mul: begin
                    r_prod <= w_prod_next;
                    r_cnt  <= r_cnt - c_last;
                    if (r_cnt == c_last) begin
                        r_result <= r_mul_hi ? w_prod_next[2*WIDTH-1:WIDTH] : w_prod_next[WIDTH-1:0];
                        r_zero   <= r_mul_hi ? (w_prod_next[2*WIDTH-1:WIDTH] == '0)
                                             : (w_prod_next[WIDTH-1:0] == '0);
                        r_state  <= c_st_done;
                    end
                end
`ifdef ALU_DIV_EN
                c_st_div: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - c_last;
                    if (r_cnt == c_last) begin
                        r_result <= r_rem_sel ? w_rem_next : w_quo_next;
                        r_zero   <= r_rem_sel ? (w_rem_next == '0) : (w_quo_next == '0);
                        r_state  <= c_st_done;
                    end
                end
`endif
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // w_is_div is only consumed by the divider branch.
    logic w_unused;
    assign w_unused = w_is_div;

endmodule
`default_nettype wire
